// File: rtl/butterfly_pkg.sv
// -----------------------------------------------------------------------------
// butterfly_pkg
//   Shared definitions for the butterfly sequencers (stream and legacy).
//   This file has no ports. It holds:
//     - state_t : the 12 sequencer states.
//     - ctrl_t  : the 8 datapath control bits, packed in one struct.
//     - PULSE_* : the control pulse set issued on each transition.
//     - is_accept_state / is_output_state : state classification helpers.
// -----------------------------------------------------------------------------
package butterfly_pkg;

    typedef enum logic [3:0] {
        S_W_RE  = 4'd0,
        S_W_IM  = 4'd1,
        S_B_RE  = 4'd2,
        S_B_IM  = 4'd3,
        S_MULT0 = 4'd4,
        S_A_RE  = 4'd5,
        S_MULT1 = 4'd6,
        S_A_IM  = 4'd7,
        S_Y_RE  = 4'd8,
        S_Y_IM  = 4'd9,
        S_Z_RE  = 4'd10,
        S_Z_IM  = 4'd11
    } state_t;

    // Bit order (MSB first) is fixed so that the PULSE_* constants can be
    // written as plain 8-bit vectors.
    typedef struct packed {
        logic load_coeff;
        logic load_b;
        logic load_mult;
        logic multiply;
        logic load_output_reg;
        logic subtract;
        logic mult_out_select;
        logic fbr_input;
    } ctrl_t;

    localparam ctrl_t CTRL_NONE   = ctrl_t'(8'b0000_0000);
    localparam ctrl_t PULSE_COEFF = ctrl_t'(8'b1000_0000); // W_RE, W_IM accept
    localparam ctrl_t PULSE_B     = ctrl_t'(8'b0100_0000); // B_RE, B_IM accept
    localparam ctrl_t PULSE_MULT0 = ctrl_t'(8'b0110_0000); // load_b + load_mult
    localparam ctrl_t PULSE_A_RE  = ctrl_t'(8'b0011_1101); // fbr, mult, lor, multiply, sub
    localparam ctrl_t PULSE_MULT1 = ctrl_t'(8'b0001_0000); // multiply
    localparam ctrl_t PULSE_A_IM  = ctrl_t'(8'b0000_1001); // fbr, lor
    localparam ctrl_t PULSE_Y_RE  = ctrl_t'(8'b0000_1010); // lor, mult_out_select
    localparam ctrl_t PULSE_Y_IM  = ctrl_t'(8'b0000_1100); // lor, subtract
    localparam ctrl_t PULSE_Z_RE  = ctrl_t'(8'b0000_1110); // lor, mos, subtract

    // States in which an input word may be accepted.
    function automatic logic is_accept_state(input state_t s);
        logic r;
        case (s)
            S_W_RE, S_W_IM, S_B_RE, S_B_IM, S_A_RE, S_A_IM: r = 1'b1;
            default:                                        r = 1'b0;
        endcase
        return r;
    endfunction

    // States in which a result word is presented on the output stream.
    function automatic logic is_output_state(input state_t s);
        logic r;
        case (s)
            S_Y_RE, S_Y_IM, S_Z_RE, S_Z_IM: r = 1'b1;
            default:                        r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/butterfly_stream_ctrl.sv
// -----------------------------------------------------------------------------
// butterfly_stream_ctrl
//   Streaming sequencer for butterfly_datapath. Takes 6 words per butterfly
//   (Re w, Im w, Re b, Im b, Re a, Im a) on a valid/ready input stream, drives
//   every datapath control pulse, and returns 4 result words (Re y, Im y,
//   Re z, Im z) on a valid/ready output stream.
//
// Ports
//   clk            : clock, all logic on posedge
//   nResetSync     : synchronous active-low reset
//   in_data/in_valid/in_ready    : input word stream
//   reuse_w        : sampled at the Im z handshake; 1 keeps w, next start at Re b
//   out_data/out_valid/out_ready : result word stream (data from dp_data_out)
//   dp_data_in     : registered copy of the last accepted input word
//   dp_data_out    : datapath result register
//   load_coeff .. fbr_input : registered single-cycle datapath controls
//   busy           : 0 only while idle waiting for the first word of a butterfly
//   bfly_count     : completed butterflies, wrapping
// -----------------------------------------------------------------------------
module butterfly_stream_ctrl
    import butterfly_pkg::*;
#(
    parameter int DATA_W  = 8,
    parameter int COUNT_W = 8
) (
    input  logic               clk,
    input  logic               nResetSync,
    input  logic [DATA_W-1:0]  in_data,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic               reuse_w,
    output logic [DATA_W-1:0]  out_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [DATA_W-1:0]  dp_data_in,
    input  logic [DATA_W-1:0]  dp_data_out,
    output logic               load_coeff,
    output logic               load_b,
    output logic               load_mult,
    output logic               multiply,
    output logic               load_output_reg,
    output logic               subtract,
    output logic               mult_out_select,
    output logic               fbr_input,
    output logic               busy,
    output logic [COUNT_W-1:0] bfly_count
);

    state_t              state_r,     state_s;
    ctrl_t               ctrl_r,      ctrl_s;
    logic                in_ready_r,  in_ready_s;
    logic                out_valid_r, out_valid_s;
    logic                busy_r,      busy_s;
    logic [COUNT_W-1:0]  count_r,     count_s;
    logic [DATA_W-1:0]   dp_data_r,   dp_data_s;
    logic                accept_s;
    logic                out_hs_s;

    assign accept_s = in_valid & in_ready_r;
    assign out_hs_s = out_valid_r & out_ready;

    // Next-state, pulse, counter and data-register selection.
    always_comb begin
        state_s   = state_r;
        ctrl_s    = CTRL_NONE;
        busy_s    = busy_r;
        count_s   = count_r;
        dp_data_s = dp_data_r;
        case (state_r)
            S_W_RE: begin
                if (accept_s) begin
                    state_s   = S_W_IM;
                    ctrl_s    = PULSE_COEFF;
                    dp_data_s = in_data;
                    busy_s    = 1'b1;
                end else begin
                    busy_s    = 1'b0;
                end
            end
            S_W_IM: begin
                if (accept_s) begin
                    state_s   = S_B_RE;
                    ctrl_s    = PULSE_COEFF;
                    dp_data_s = in_data;
                end else begin
                    state_s   = S_W_IM;
                end
            end
            S_B_RE: begin
                // busy is still 0 here when the state was entered through reuse_w
                if (accept_s) begin
                    state_s   = S_B_IM;
                    ctrl_s    = PULSE_B;
                    dp_data_s = in_data;
                    busy_s    = 1'b1;
                end else begin
                    state_s   = S_B_RE;
                end
            end
            S_B_IM: begin
                if (accept_s) begin
                    state_s   = S_MULT0;
                    ctrl_s    = PULSE_B;
                    dp_data_s = in_data;
                end else begin
                    state_s   = S_B_IM;
                end
            end
            S_MULT0: begin
                state_s = S_A_RE;
                ctrl_s  = PULSE_MULT0;
            end
            S_A_RE: begin
                if (accept_s) begin
                    state_s   = S_MULT1;
                    ctrl_s    = PULSE_A_RE;
                    dp_data_s = in_data;
                end else begin
                    state_s   = S_A_RE;
                end
            end
            S_MULT1: begin
                state_s = S_A_IM;
                ctrl_s  = PULSE_MULT1;
            end
            S_A_IM: begin
                if (accept_s) begin
                    state_s   = S_Y_RE;
                    ctrl_s    = PULSE_A_IM;
                    dp_data_s = in_data;
                end else begin
                    state_s   = S_A_IM;
                end
            end
            S_Y_RE: begin
                if (out_hs_s) begin
                    state_s = S_Y_IM;
                    ctrl_s  = PULSE_Y_RE;
                end else begin
                    state_s = S_Y_RE;
                end
            end
            S_Y_IM: begin
                if (out_hs_s) begin
                    state_s = S_Z_RE;
                    ctrl_s  = PULSE_Y_IM;
                end else begin
                    state_s = S_Y_IM;
                end
            end
            S_Z_RE: begin
                if (out_hs_s) begin
                    state_s = S_Z_IM;
                    ctrl_s  = PULSE_Z_RE;
                end else begin
                    state_s = S_Z_RE;
                end
            end
            S_Z_IM: begin
                if (out_hs_s) begin
                    state_s = reuse_w ? S_B_RE : S_W_RE;
                    count_s = count_r + {{(COUNT_W-1){1'b0}}, 1'b1};
                    busy_s  = 1'b0;
                end else begin
                    state_s = S_Z_IM;
                end
            end
            default: begin
                state_s = S_W_RE;
                ctrl_s  = CTRL_NONE;
                busy_s  = 1'b0;
            end
        endcase
    end

    // in_ready follows the state being entered. out_valid is set only once the
    // FSM has spent one full cycle in an output state, which gives the
    // datapath output register the cycle it needs to capture the result.
    assign in_ready_s  = is_accept_state(state_s);
    assign out_valid_s = is_output_state(state_s) && (state_s == state_r);

    // State and registered outputs, with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!nResetSync) begin
            state_r     <= S_W_RE;
            ctrl_r      <= CTRL_NONE;
            in_ready_r  <= 1'b0;
            out_valid_r <= 1'b0;
            busy_r      <= 1'b0;
            count_r     <= {COUNT_W{1'b0}};
            dp_data_r   <= {DATA_W{1'b0}};
        end else begin
            state_r     <= state_s;
            ctrl_r      <= ctrl_s;
            in_ready_r  <= in_ready_s;
            out_valid_r <= out_valid_s;
            busy_r      <= busy_s;
            count_r     <= count_s;
            dp_data_r   <= dp_data_s;
        end
    end

    assign in_ready        = in_ready_r;
    assign out_valid       = out_valid_r;
    assign out_data        = dp_data_out;
    assign dp_data_in      = dp_data_r;
    assign busy            = busy_r;
    assign bfly_count      = count_r;
    assign load_coeff      = ctrl_r.load_coeff;
    assign load_b          = ctrl_r.load_b;
    assign load_mult       = ctrl_r.load_mult;
    assign multiply        = ctrl_r.multiply;
    assign load_output_reg = ctrl_r.load_output_reg;
    assign subtract        = ctrl_r.subtract;
    assign mult_out_select = ctrl_r.mult_out_select;
    assign fbr_input       = ctrl_r.fbr_input;

endmodule

// File: tb/tb_butterfly_stream_ctrl.sv
// -----------------------------------------------------------------------------
// tb_butterfly_stream_ctrl
//   Bench for butterfly_stream_ctrl. A small stand-in datapath reacts to the
//   control pulses (it grabs dp_data_in on each load pulse and presents the
//   result word selected by each output pulse). Expected results come from a
//   Q1.7 butterfly reference (y = a + w*b, z = a - w*b) fed with the words
//   the bench itself sent.
// -----------------------------------------------------------------------------
module tb_butterfly_stream_ctrl;

    localparam int DATA_W  = 8;
    localparam int COUNT_W = 8;

    logic               clk = 1'b0;
    logic               nResetSync;
    logic [DATA_W-1:0]  in_data;
    logic               in_valid;
    logic               in_ready;
    logic               reuse_w;
    logic [DATA_W-1:0]  out_data;
    logic               out_valid;
    logic               out_ready;
    logic [DATA_W-1:0]  dp_data_in;
    logic [DATA_W-1:0]  dp_data_out;
    logic               load_coeff, load_b, load_mult, multiply;
    logic               load_output_reg, subtract, mult_out_select, fbr_input;
    logic               busy;
    logic [COUNT_W-1:0] bfly_count;

    int tests_run    = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    butterfly_stream_ctrl #(.DATA_W(DATA_W), .COUNT_W(COUNT_W)) dut (
        .clk(clk), .nResetSync(nResetSync),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .reuse_w(reuse_w),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .dp_data_in(dp_data_in), .dp_data_out(dp_data_out),
        .load_coeff(load_coeff), .load_b(load_b), .load_mult(load_mult),
        .multiply(multiply), .load_output_reg(load_output_reg),
        .subtract(subtract), .mult_out_select(mult_out_select),
        .fbr_input(fbr_input), .busy(busy), .bfly_count(bfly_count)
    );

    // Reference butterfly, Q1.7: returns {Re y, Im y, Re z, Im z}.
    function automatic logic [31:0] bfly_ref(input logic [7:0] wr, wi, br, bi, ar, ai);
        int swr, swi, sbr, sbi, p_re, p_im;
        logic [7:0] pr, pi;
        swr = $signed(wr); swi = $signed(wi);
        sbr = $signed(br); sbi = $signed(bi);
        p_re = (swr * sbr - swi * sbi) >>> 7;
        p_im = (swr * sbi + swi * sbr) >>> 7;
        pr = p_re[7:0];
        pi = p_im[7:0];
        return {ar + pr, ai + pi, ar - pr, ai - pi};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // ---------------- stand-in datapath ----------------
    logic [7:0]  cw [2];
    logic [7:0]  cb [2];
    logic [7:0]  ca [2];
    int          cw_n = 0, cb_n = 0;
    int          coeff_pulses = 0, pulse_cnt = 0;
    logic [7:0]  dp_next = 8'h00;
    logic [31:0] dp_res;

    always @(negedge clk) begin
        if (load_coeff) begin cw[cw_n % 2] = dp_data_in; cw_n++; coeff_pulses++; end
        if (load_b && !load_mult) begin cb[cb_n % 2] = dp_data_in; cb_n++; end
        if (fbr_input && multiply)  ca[0] = dp_data_in;
        if (fbr_input && !multiply) ca[1] = dp_data_in;
        if (load_output_reg) begin
            dp_res = bfly_ref(cw[0], cw[1], cb[0], cb[1], ca[0], ca[1]);
            if (fbr_input && !multiply)                           dp_next = dp_res[31:24];
            else if (!fbr_input && mult_out_select && !subtract)  dp_next = dp_res[23:16];
            else if (!fbr_input && !mult_out_select && subtract)  dp_next = dp_res[15:8];
            else if (!fbr_input && mult_out_select && subtract)   dp_next = dp_res[7:0];
        end
        if ({load_coeff, load_b, load_mult, multiply, load_output_reg,
             subtract, mult_out_select, fbr_input} != 8'h00) pulse_cnt++;
    end

    always @(posedge clk) dp_data_out = dp_next;

    // ---------------- stimulus helpers ----------------
    task automatic send_word(input logic [7:0] d, input int gap);
        int t;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (gap) @(negedge clk);
        in_data  = d;
        in_valid = 1'b1;
        t = 0;
        while (!in_ready && t < 50) begin @(negedge clk); t++; end
        if (t >= 50) check("in_ready_timeout", 32'd0, 32'd1);
        else @(posedge clk);
    endtask

    task automatic recv_word(input int stall, output logic [7:0] d);
        int t;
        @(negedge clk);
        out_ready = 1'b0;
        repeat (stall) @(negedge clk);
        out_ready = 1'b1;
        t = 0;
        while (!out_valid && t < 50) begin @(negedge clk); t++; end
        if (t >= 50) check("out_valid_timeout", 32'd0, 32'd1);
        d = out_data;
        @(posedge clk);
    endtask

    task automatic run_bfly(input logic [7:0] words [6], input bit send_w, input bit reuse,
                            input int gap_max, input int stall_max, output logic [7:0] res [4]);
        for (int i = (send_w ? 0 : 2); i < 6; i++)
            send_word(words[i], $urandom_range(0, gap_max));
        @(negedge clk);
        in_valid = 1'b0;
        reuse_w  = reuse;
        for (int i = 0; i < 4; i++) recv_word($urandom_range(0, stall_max), res[i]);
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        nResetSync = 1'b0;
        in_valid   = 1'b0;
        out_ready  = 1'b0;
        reuse_w    = 1'b0;
        repeat (2) @(negedge clk);
        check("reset_outputs",
              {in_ready, out_valid, busy, bfly_count, dp_data_in, load_coeff, load_b, load_mult,
               multiply, load_output_reg, subtract, mult_out_select, fbr_input}, 32'd0);
        nResetSync = 1'b1;
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic [7:0] w_re, w_im, b_re, b_im, a_re, a_im;
        bit         send_w;
        bit         reuse;
        logic [7:0] y_re, y_im, z_re, z_im;
    } vec_t;

    vec_t tbl [5];

    initial begin
        logic [7:0] words [6];
        logic [7:0] res [4];
        logic [7:0] w_cur [2];
        logic [31:0] exp_r;
        logic [7:0] held;
        int snap, snap_p;
        bit prev_reuse, reuse_now, still;

        nResetSync = 1'b0; in_data = 8'h00; in_valid = 1'b0;
        out_ready  = 1'b0; reuse_w = 1'b0;

        tbl[0] = '{8'h00, 8'h00, 8'h55, 8'h33, 8'h10, 8'h20, 1'b1, 1'b0, 8'h10, 8'h20, 8'h10, 8'h20};
        tbl[1] = '{8'h40, 8'h00, 8'h20, 8'h00, 8'h10, 8'h00, 1'b1, 1'b1, 8'h20, 8'h00, 8'h00, 8'h00};
        tbl[2] = '{8'h40, 8'h00, 8'h20, 8'h20, 8'h00, 8'h00, 1'b0, 1'b0, 8'h10, 8'h10, 8'hF0, 8'hF0};
        tbl[3] = '{8'h00, 8'h40, 8'h20, 8'h00, 8'h00, 8'h00, 1'b1, 1'b0, 8'h00, 8'h10, 8'h00, 8'hF0};
        tbl[4] = '{8'hC0, 8'h00, 8'h40, 8'h40, 8'h10, 8'h10, 1'b1, 1'b0, 8'hF0, 8'hF0, 8'h30, 8'h30};

        do_reset();
        @(negedge clk);
        check("idle_in_ready", {31'd0, in_ready}, 32'd1);

        // Table-driven butterflies (includes reuse_w path on rows 1 -> 2).
        for (int r = 0; r < 5; r++) begin
            words = '{tbl[r].w_re, tbl[r].w_im, tbl[r].b_re, tbl[r].b_im, tbl[r].a_re, tbl[r].a_im};
            snap = coeff_pulses;
            run_bfly(words, tbl[r].send_w, tbl[r].reuse, 1, 1, res);
            check($sformatf("tbl%0d_y_re", r), res[0], tbl[r].y_re);
            check($sformatf("tbl%0d_y_im", r), res[1], tbl[r].y_im);
            check($sformatf("tbl%0d_z_re", r), res[2], tbl[r].z_re);
            check($sformatf("tbl%0d_z_im", r), res[3], tbl[r].z_im);
            check($sformatf("tbl%0d_idle_busy", r), {31'd0, busy}, 32'd0);
            check($sformatf("tbl%0d_coeff_pulses", r), coeff_pulses - snap, tbl[r].send_w ? 2 : 0);
        end
        check("tbl_bfly_count", bfly_count, 32'd5);

        // Output stall at Im y, plus state-entry and handshake timing.
        do_reset();
        words = '{8'hC0, 8'h00, 8'h40, 8'h40, 8'h10, 8'h10};
        for (int i = 0; i < 6; i++) send_word(words[i], 0);
        @(negedge clk);
        in_valid = 1'b0;
        check("entry_no_valid", {31'd0, out_valid}, 32'd0);
        @(negedge clk);
        check("valid_1_after_entry", {31'd0, out_valid}, 32'd1);
        check("stall_y_re", out_data, 8'hF0);
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        check("hs_gap_cycle1", {31'd0, out_valid}, 32'd0);
        @(negedge clk);
        check("hs_gap_cycle2", {31'd0, out_valid}, 32'd1);
        held = out_data;
        snap_p = pulse_cnt;
        still = 1'b1;
        repeat (20) begin
            @(negedge clk);
            if (!out_valid || out_data !== held) still = 1'b0;
        end
        check("stall_stable", {31'd0, still}, 32'd1);
        check("stall_data", held, 8'hF0);
        check("stall_no_pulses", pulse_cnt - snap_p, 32'd0);
        check("stall_busy", {31'd0, busy}, 32'd1);
        out_ready = 1'b1;
        @(posedge clk);
        recv_word(0, res[2]);
        recv_word(2, res[3]);
        @(negedge clk);
        out_ready = 1'b0;
        check("stall_z_re", res[2], 8'h30);
        check("stall_z_im", res[3], 8'h30);
        check("stall_bfly_count", bfly_count, 32'd1);

        // Reset while in S_MULT1, then a full butterfly.
        do_reset();
        words = '{8'h40, 8'h00, 8'h20, 8'h00, 8'h10, 8'h00};
        for (int i = 0; i < 5; i++) send_word(words[i], 0);
        @(negedge clk);
        in_valid   = 1'b0;
        nResetSync = 1'b0;
        @(negedge clk);
        check("mult1_reset_outputs",
              {in_ready, out_valid, busy, bfly_count, dp_data_in, load_coeff, load_b, load_mult,
               multiply, load_output_reg, subtract, mult_out_select, fbr_input}, 32'd0);
        nResetSync = 1'b1;
        run_bfly(words, 1'b1, 1'b0, 0, 0, res);
        check("after_reset_y_re", res[0], 8'h20);
        check("after_reset_y_im", res[1], 8'h00);
        check("after_reset_z_re", res[2], 8'h00);
        check("after_reset_z_im", res[3], 8'h00);
        check("after_reset_count", bfly_count, 32'd1);

        // Randomised traffic: gaps, stalls, random reuse_w.
        do_reset();
        prev_reuse = 1'b0;
        w_cur = '{8'h00, 8'h00};
        for (int n = 0; n < 200; n++) begin
            for (int i = 0; i < 6; i++) words[i] = 8'($urandom_range(0, 255));
            if (!prev_reuse) w_cur = '{words[0], words[1]};
            reuse_now = 1'($urandom_range(0, 1));
            exp_r = bfly_ref(w_cur[0], w_cur[1], words[2], words[3], words[4], words[5]);
            run_bfly(words, !prev_reuse, reuse_now, 3, 3, res);
            check($sformatf("rnd%0d_y_re", n), res[0], exp_r[31:24]);
            check($sformatf("rnd%0d_y_im", n), res[1], exp_r[23:16]);
            check($sformatf("rnd%0d_z_re", n), res[2], exp_r[15:8]);
            check($sformatf("rnd%0d_z_im", n), res[3], exp_r[7:0]);
            prev_reuse = reuse_now;
        end
        check("rnd_bfly_count", bfly_count, 32'd200);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, got timeout, expected finish");
        $fatal(1);
    end

endmodule
